// File: rtl/io_row_burst_master.sv
// Wishbone master that moves multi-row bursts between a row-wide data memory and the bus.
// The bus is held under one CYC_O ownership for the whole burst; a missing ACK aborts it with an error.
module io_row_burst_master #(
  parameter int unsigned WB_WIDTH = 32,
  parameter int unsigned ELEMENTS = 3,
  parameter int unsigned DADDR_W  = 7,
  parameter int unsigned ROWS_W   = 4,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         iStart,
  input  logic                         iWrite,
  input  logic [WB_WIDTH-1:0]          iBusAddress,
  input  logic [DADDR_W-1:0]           iMemAddress,
  input  logic [ROWS_W-1:0]            iRowCount,
  output logic                         oBusy,
  output logic                         oDone,
  output logic                         oError,
  output logic [DADDR_W-1:0]           oMemReadAddress,
  input  logic [ELEMENTS*WB_WIDTH-1:0] iMemReadData,
  output logic [DADDR_W-1:0]           oMemWriteAddress,
  output logic [ELEMENTS*WB_WIDTH-1:0] oMemWriteData,
  output logic                         oMemWriteEnable,
  output logic [WB_WIDTH-1:0]          ADR_O,
  output logic [WB_WIDTH-1:0]          DAT_O,
  input  logic [WB_WIDTH-1:0]          DAT_I,
  output logic                         WE_O,
  output logic                         STB_O,
  output logic                         CYC_O,
  input  logic                         ACK_I,
  input  logic                         GNT_I
);

  // The element counter must be able to hold ELEMENTS itself ("row finished").
  localparam int unsigned EW = $clog2(ELEMENTS + 1);
  localparam int unsigned IW = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [EW-1:0] ElemEnd = EW'(ELEMENTS);
  localparam logic [IW-1:0] LastIdx = IW'(ELEMENTS - 1);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    StIdle,
    StReq,
    StFetch1,
    StFetch2,
    StXfer,
    StGap,
    StStore,
    StNext,
    StDone
  } state_e;

  state_e r_state, w_state_d;

  logic                               r_write;
  logic [WB_WIDTH-1:0]                r_bus_addr;
  logic [DADDR_W-1:0]                 r_mem_row;
  logic [ROWS_W-1:0]                  r_rows;
  logic [ROWS_W-1:0]                  r_row;
  logic [EW-1:0]                      r_elem;
  logic [TW-1:0]                      r_tmo;
  logic                               r_err;
  logic [ELEMENTS-1:0][WB_WIDTH-1:0]  r_buf;

  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_slot;
  logic          w_timeout;

  // Element 0 is the most significant slice of the row.
  assign w_idx  = r_elem[IW-1:0];
  assign w_slot = LastIdx - w_idx;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d       = r_state;
    w_timeout       = 1'b0;
    oBusy           = (r_state != StIdle);
    oDone           = 1'b0;
    oError          = 1'b0;
    oMemWriteEnable = 1'b0;
    ADR_O           = '0;
    DAT_O           = '0;
    WE_O            = 1'b0;
    STB_O           = 1'b0;
    CYC_O           = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (iStart) w_state_d = StReq;
      end
      StReq: begin
        CYC_O = 1'b1;
        if (GNT_I) w_state_d = r_write ? StFetch1 : StXfer;
      end
      StFetch1: begin
        CYC_O     = 1'b1;
        w_state_d = StFetch2;
      end
      StFetch2: begin
        CYC_O     = 1'b1;
        w_state_d = StXfer;
      end
      StXfer: begin
        CYC_O = 1'b1;
        STB_O = 1'b1;
        WE_O  = r_write;
        ADR_O = r_bus_addr;
        DAT_O = r_buf[w_slot];
        if (ACK_I) begin
          w_state_d = StGap;
        end else if (r_tmo == TmoLast) begin
          w_state_d = StDone;
          w_timeout = 1'b1;
        end
      end
      StGap: begin
        CYC_O = 1'b1;
        if (r_elem == ElemEnd) w_state_d = r_write ? StNext : StStore;
        else                   w_state_d = StXfer;
      end
      StStore: begin
        CYC_O           = 1'b1;
        oMemWriteEnable = 1'b1;
        w_state_d       = StNext;
      end
      StNext: begin
        CYC_O = 1'b1;
        if (r_row == r_rows) w_state_d = StDone;
        else                 w_state_d = r_write ? StFetch1 : StXfer;
      end
      StDone: begin
        oDone     = 1'b1;
        oError    = r_err;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_write    <= 1'b0;
      r_bus_addr <= '0;
      r_mem_row  <= '0;
      r_rows     <= '0;
      r_row      <= '0;
      r_elem     <= '0;
      r_tmo      <= '0;
      r_err      <= 1'b0;
      r_buf      <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (iStart) begin
            r_write    <= iWrite;
            r_bus_addr <= iBusAddress;
            r_mem_row  <= iMemAddress;
            r_rows     <= iRowCount;
            r_row      <= '0;
            r_elem     <= '0;
            r_tmo      <= '0;
            r_err      <= 1'b0;
          end
        end
        StFetch2: r_buf <= iMemReadData;
        StXfer: begin
          if (ACK_I) begin
            if (!r_write) r_buf[w_slot] <= DAT_I;
            r_bus_addr <= r_bus_addr + 1'b1;
            r_elem     <= r_elem + 1'b1;
          end else begin
            r_tmo <= r_tmo + 1'b1;
            if (w_timeout) r_err <= 1'b1;
          end
        end
        // Clearing here makes every STB_O rise start a fresh timeout window.
        StGap: r_tmo <= '0;
        StNext: begin
          r_tmo <= '0;
          if (r_row != r_rows) begin
            r_row     <= r_row + 1'b1;
            r_mem_row <= r_mem_row + 1'b1;
            r_elem    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign oMemReadAddress  = r_mem_row;
  assign oMemWriteAddress = r_mem_row;
  assign oMemWriteData    = r_buf;

endmodule

// File: tb/tb_io_row_burst_master.sv
// Directed bench for io_row_burst_master: a sync-RAM and Wishbone-slave model drive the DUT and a
// queue-based scoreboard built from the burst parameters checks every bus beat and memory write.
module tb_io_row_burst_master;

  localparam int W   = 32;
  localparam int E   = 3;
  localparam int DW  = 7;
  localparam int RW  = 4;
  localparam int TMO = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            iStart, iWrite;
  logic [W-1:0]    iBusAddress;
  logic [DW-1:0]   iMemAddress;
  logic [RW-1:0]   iRowCount;
  logic            oBusy, oDone, oError;
  logic [DW-1:0]   oMemReadAddress, oMemWriteAddress;
  logic [E*W-1:0]  iMemReadData, oMemWriteData;
  logic            oMemWriteEnable;
  logic [W-1:0]    ADR_O, DAT_O;
  logic [W-1:0]    DAT_I = '0;
  logic            WE_O, STB_O, CYC_O;
  logic            ACK_I = 1'b0;
  logic            GNT_I;

  io_row_burst_master #(
    .WB_WIDTH(W), .ELEMENTS(E), .DADDR_W(DW), .ROWS_W(RW), .TIMEOUT(TMO)
  ) dut (
    .Clock(clk), .Reset(rst_n), .iStart(iStart), .iWrite(iWrite),
    .iBusAddress(iBusAddress), .iMemAddress(iMemAddress), .iRowCount(iRowCount),
    .oBusy(oBusy), .oDone(oDone), .oError(oError),
    .oMemReadAddress(oMemReadAddress), .iMemReadData(iMemReadData),
    .oMemWriteAddress(oMemWriteAddress), .oMemWriteData(oMemWriteData),
    .oMemWriteEnable(oMemWriteEnable), .ADR_O(ADR_O), .DAT_O(DAT_O), .DAT_I(DAT_I),
    .WE_O(WE_O), .STB_O(STB_O), .CYC_O(CYC_O), .ACK_I(ACK_I), .GNT_I(GNT_I)
  );

  // Synchronous RAM with a preload port for the stimulus.
  logic [E*W-1:0] mem [128];
  logic [E*W-1:0] mem_rd;
  logic           pl_en;
  logic [DW-1:0]  pl_addr;
  logic [E*W-1:0] pl_data;
  assign iMemReadData = mem_rd;
  always @(posedge clk) begin
    mem_rd <= mem[oMemReadAddress];
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (oMemWriteEnable) mem[oMemWriteAddress] <= oMemWriteData;
  end

  // Slave: ACK in the cycle after STB_O is seen, only for the first ack_limit beats of a burst.
  int           acks_given = 0;
  int           ack_start;
  int           ack_limit;
  logic [W-1:0] rd_words [64];
  always @(posedge clk) begin
    if (!rst_n) begin
      ACK_I <= 1'b0;
    end else if (STB_O && !ACK_I && (acks_given - ack_start) < ack_limit) begin
      ACK_I      <= 1'b1;
      DAT_I      <= rd_words[6'(acks_given - ack_start)];
      acks_given <= acks_given + 1;
    end else begin
      ACK_I <= 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [W-1:0] adr; logic we; logic [W-1:0] dat; logic chk; } beat_t;
  typedef struct { logic [DW-1:0] adr; logic [E*W-1:0] dat; } wr_t;
  beat_t exp_beats[$];
  wr_t   exp_wrs[$];

  int           n_cmp = 0;
  int           n_bad = 0;
  int           t_start;
  int           done_seen;
  int           stb_run;
  int           stb_max;
  logic         exp_err;
  logic [W-1:0] last_adr, last_dat;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle_checks();
    beat_t b;
    wr_t   w;
    if (rst_n) begin
      check("cyc_held", CYC_O, oBusy && !oDone);
      if (oError) check("error_without_done", oDone, 1'b1);
      if (STB_O) stb_run++;
      else if (stb_run > 0) begin
        if (stb_run > stb_max) stb_max = stb_run;
        stb_run = 0;
      end
      if (STB_O && ACK_I) begin
        check("beat_expected", exp_beats.size() > 0, 1'b1);
        if (exp_beats.size() > 0) begin
          b = exp_beats.pop_front();
          check("adr_o", ADR_O, b.adr);
          check("we_o", WE_O, b.we);
          if (b.chk) check("dat_o", DAT_O, b.dat);
          last_adr = ADR_O;
          last_dat = DAT_O;
        end
      end
      if (oMemWriteEnable) begin
        check("memwr_expected", exp_wrs.size() > 0, 1'b1);
        if (exp_wrs.size() > 0) begin
          w = exp_wrs.pop_front();
          check("memwr_addr", oMemWriteAddress, w.adr);
          check("memwr_data", oMemWriteData, w.dat);
        end
      end
      if (oDone) begin
        done_seen++;
        check("error_flag", oError, exp_err);
      end
    end
  endtask

  // Read burst model: beat k hits base+k; each fully acked row lands at mrow+r, element 0 on top.
  task automatic expect_read(input logic [W-1:0] base, input logic [DW-1:0] mrow, input int rows,
                             input int acks);
    beat_t          b;
    wr_t            w;
    logic [E*W-1:0] d;
    for (int k = 0; k < acks; k++) begin
      b.adr = base + W'(k); b.we = 1'b0; b.dat = '0; b.chk = 1'b0;
      exp_beats.push_back(b);
    end
    for (int r = 0; r <= rows && (r + 1) * E <= acks; r++) begin
      for (int e = 0; e < E; e++) d[(E-1-e)*W +: W] = rd_words[6'(r * E + e)];
      w.adr = mrow + DW'(r);
      w.dat = d;
      exp_wrs.push_back(w);
    end
  endtask

  task automatic expect_write(input logic [W-1:0] base, input logic [DW-1:0] mrow, input int rows);
    beat_t          b;
    logic [DW-1:0]  a;
    logic [E*W-1:0] rowv;
    for (int r = 0; r <= rows; r++) begin
      a    = mrow + DW'(r);
      rowv = mem[a];
      for (int e = 0; e < E; e++) begin
        b.adr = base + W'(r * E + e); b.we = 1'b1; b.dat = rowv[(E-1-e)*W +: W]; b.chk = 1'b1;
        exp_beats.push_back(b);
      end
    end
  endtask

  task automatic setup(input int lim, input logic err);
    ack_start = acks_given;
    ack_limit = lim;
    exp_err   = err;
    done_seen = 0;
    stb_max   = 0;
  endtask

  task automatic preload(input logic [DW-1:0] a, input logic [E*W-1:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic start_burst(input logic wr, input logic [W-1:0] ba, input logic [DW-1:0] ma,
                             input logic [RW-1:0] rc);
    @(negedge clk);
    iWrite = wr; iBusAddress = ba; iMemAddress = ma; iRowCount = rc; iStart = 1'b1;
    t_start = cyc;
    @(negedge clk);
    iStart = 1'b0;
  endtask

  task automatic run_checks(input string tag, input int exp_lat);
    int lat;
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (oDone) begin
        lat = cyc - t_start;
        break;
      end
    end
    if (exp_lat >= 0) check({tag, "_latency"}, lat, exp_lat);
    else              check({tag, "_finished"}, lat >= 0, 1'b1);
    @(negedge clk);
    check({tag, "_done_count"}, done_seen, 1);
    check({tag, "_beats_left"}, exp_beats.size(), 0);
    check({tag, "_writes_left"}, exp_wrs.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    rst_n = 1'b0; iStart = 1'b0; iWrite = 1'b0; iBusAddress = '0; iMemAddress = '0;
    iRowCount = '0; GNT_I = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    stb_run = 0; stb_max = 0; done_seen = 0; exp_err = 1'b0; t_start = 0;
    ack_start = 0; ack_limit = 0; last_adr = '0; last_dat = '0;
    fork
      forever begin
        @(negedge clk);
        cycle_checks();
      end
    join_none

    repeat (3) @(negedge clk);
    check("rst_cyc", CYC_O, 1'b0);
    check("rst_stb", STB_O, 1'b0);
    check("rst_busy", oBusy, 1'b0);
    check("rst_done", oDone, 1'b0);
    check("rst_memwe", oMemWriteEnable, 1'b0);
    check("rst_rdaddr", oMemReadAddress, 7'h00);
    rst_n = 1'b1;

    // 1: single-row read
    rd_words[0] = 32'hA; rd_words[1] = 32'hB; rd_words[2] = 32'hC;
    setup(3, 1'b0);
    expect_read(32'h100, 7'h10, 0, 3);
    start_burst(1'b0, 32'h100, 7'h10, 4'd0);
    run_checks("t1", 3 * E + 4);
    check("t1_mem_row", mem[7'h10], {32'hA, 32'hB, 32'hC});

    // 2: two-row write
    preload(7'h20, {32'd1, 32'd2, 32'd3});
    preload(7'h21, {32'd4, 32'd5, 32'd6});
    setup(6, 1'b0);
    expect_write(32'h200, 7'h20, 1);
    start_burst(1'b1, 32'h200, 7'h20, 4'd1);
    run_checks("t2", 26);
    check("t2_last_adr", last_adr, 32'h205);
    check("t2_last_dat", last_dat, 32'd6);

    // 3: grant withheld for five cycles
    GNT_I = 1'b0;
    setup(3, 1'b0);
    expect_write(32'h300, 7'h20, 0);
    start_burst(1'b1, 32'h300, 7'h20, 4'd0);
    for (int i = 0; i < 5; i++) begin
      check("t3_req_cyc", CYC_O, 1'b1);
      check("t3_req_stb", STB_O, 1'b0);
      check("t3_req_memwe", oMemWriteEnable, 1'b0);
      @(negedge clk);
    end
    GNT_I = 1'b1;
    run_checks("t3", 3 * E + 5 + 5);

    // 4: second element of row 1 never acked
    for (int i = 0; i < 6; i++) rd_words[i] = 32'h11 + i;
    preload(7'h31, {3{32'hDEAD_BEEF}});
    setup(E + 1, 1'b1);
    expect_read(32'h400, 7'h30, 1, E + 1);
    start_burst(1'b0, 32'h400, 7'h30, 4'd1);
    run_checks("t4", 271);
    check("t4_stb_window", stb_max, TMO);
    check("t4_row0_kept", mem[7'h30], {32'h11, 32'h12, 32'h13});
    check("t4_row1_untouched", mem[7'h31], {3{32'hDEAD_BEEF}});

    // 5: memory row and bus address wrap, stray iStart mid-burst
    for (int i = 0; i < 6; i++) rd_words[i] = 32'h21 + i;
    setup(6, 1'b0);
    expect_read(32'hFFFF_FFFE, 7'h7F, 1, 6);
    start_burst(1'b0, 32'hFFFF_FFFE, 7'h7F, 4'd1);
    repeat (4) @(negedge clk);
    iStart = 1'b1; iWrite = 1'b1; iBusAddress = 32'h999; iMemAddress = 7'h05; iRowCount = 4'd3;
    @(negedge clk);
    iStart = 1'b0;
    run_checks("t5", 24);
    check("t5_row_7f", mem[7'h7F], {32'h21, 32'h22, 32'h23});
    check("t5_row_00", mem[7'h00], {32'h24, 32'h25, 32'h26});
    repeat (3) @(negedge clk);
    check("t5_no_restart", oBusy, 1'b0);

    // 6: asynchronous reset in the middle of a transfer, then a clean burst
    for (int i = 0; i < 12; i++) rd_words[i] = 32'h31 + i;
    setup(12, 1'b0);
    expect_read(32'h500, 7'h40, 3, 12);
    start_burst(1'b0, 32'h500, 7'h40, 4'd3);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (STB_O) found = 1'b1;
    end
    check("t6_stb_seen", found, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_cyc", CYC_O, 1'b0);
    check("t6_rst_stb", STB_O, 1'b0);
    check("t6_rst_busy", oBusy, 1'b0);
    repeat (2) @(negedge clk);
    exp_beats.delete();
    exp_wrs.delete();
    stb_run = 0;
    rst_n = 1'b1;
    setup(3, 1'b0);
    expect_write(32'h600, 7'h20, 0);
    start_burst(1'b1, 32'h600, 7'h20, 4'd0);
    run_checks("t6_after", 3 * E + 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
